// File: rtl/fifo_stream_drain_if.sv
// Valid/ready stream carrying words from fifo_stream_drain to the next stage.
//   m_data  : stream word (master -> slave)
//   m_valid : word on m_data is valid (master -> slave)
//   m_ready : slave accepts the word this cycle (slave -> master)
interface fifo_stream_drain_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_stream_drain.sv
// Drains a one-cycle-latency circular FIFO into a valid/ready stream through a
// 3-entry skid buffer; counts delivered words and keeps a sticky underflow flag.
//   clk, rst_n     : clock, async active-low reset
//   en             : allow new FIFO reads (buffered/in-flight words still drain)
//   fifo_empty     : FIFO empty status
//   fifo_underflow : FIFO underflow pulse
//   fifo_data      : FIFO data_out, valid the cycle after a read
//   fifo_rd        : FIFO read strobe
//   strm           : stream master (m_data / m_valid / m_ready)
//   byte_cnt       : stream transfers since reset, wraps
//   err_underflow  : sticky underflow flag
//   clr_err        : synchronous clear of err_underflow (set has priority)
module fifo_stream_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  fifo_stream_drain_if.master   strm,
  output logic [CNT_WIDTH-1:0]  byte_cnt,
  output logic                  err_underflow,
  input  logic                  clr_err
);

  localparam int unsigned DEPTH = 3;

  logic [DATA_WIDTH-1:0] skid_mem [DEPTH];
  logic [1:0]            occ;
  logic                  pend;
  logic [1:0]            wr_idx;
  logic [1:0]            rd_idx;
  logic                  xfer_c;

  // Issue a read only when the buffer can absorb it plus any word still in flight.
  assign fifo_rd = rst_n && en && !fifo_empty && ((3'(occ) + 3'(pend)) < 3'(DEPTH));

  assign strm.m_valid = (occ != 2'd0);
  assign strm.m_data  = skid_mem[rd_idx];
  assign xfer_c       = strm.m_valid && strm.m_ready;

  // Skid buffer: capture the word returned by last cycle's read, pop on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        skid_mem[i] <= '0;
      end
      occ    <= 2'd0;
      pend   <= 1'b0;
      wr_idx <= 2'd0;
      rd_idx <= 2'd0;
    end else begin
      pend <= fifo_rd;
      if (pend) begin
        skid_mem[wr_idx] <= fifo_data;
        wr_idx           <= (wr_idx == 2'd2) ? 2'd0 : wr_idx + 2'd1;
      end
      if (xfer_c) begin
        rd_idx <= (rd_idx == 2'd2) ? 2'd0 : rd_idx + 2'd1;
      end
      occ <= occ + 2'(pend) - 2'(xfer_c);
    end
  end

  // Delivered-word counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (xfer_c) begin
      byte_cnt <= byte_cnt + CNT_WIDTH'(1);
    end
  end

  // Sticky underflow flag; a new underflow beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (fifo_underflow) begin
      err_underflow <= 1'b1;
    end else if (clr_err) begin
      err_underflow <= 1'b0;
    end
  end

  // Buffered plus in-flight words can never exceed the buffer depth.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ((3'(occ) + 3'(pend)) <= 3'(DEPTH));
    end
  end

endmodule
